bcd_tube_feeder: RTL and testbench
==================================

BCD_TUBE_FEEDER -- requirements
Module: bcd_tube_feeder

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1; asynchronous, active-low.
REQ-003 SHALL have port WE, input, 1, CPU bus write enable.
REQ-004 SHALL have port BE, input, 4, CPU bus byte enables.
REQ-005 SHALL have port Addr, input, 32, CPU bus byte address.
REQ-006 SHALL have port Din, input, 32, CPU bus write data.
REQ-007 SHALL have port Dout, output, 32, combinational read data.
REQ-008 SHALL have port tube_WE, output, 1, write strobe to the tube display driver bus port.
REQ-009 SHALL have port tube_Addr, output, 32, address to the tube display driver.
REQ-010 SHALL have port tube_Din, output, 32, data to the tube display driver.

Function
REQ-011 SHALL decode window 0x0000_7f40..0x0000_7f47: VALUE at offset 0 (Addr[2]=0), STATUS at offset 4 (Addr[2]=1).
REQ-012 SHALL accept a VALUE write only when WE=1, address in window, Addr[2]=0, BE=4'b1111, and state=IDLE; accepted write latches Din into value_reg and starts a conversion.
REQ-013 SHALL ignore a VALUE write with BE!=4'b1111 (no state change, no flag change).
REQ-014 SHALL, on a VALUE write with full BE while not IDLE, leave value_reg and conversion untouched and set sticky overrun (STATUS bit2).
REQ-015 SHALL have states IDLE, CONV, WRITE: IDLE->CONV on accepted write with Din<=99_999_999; IDLE->WRITE on accepted write with Din>99_999_999; CONV->WRITE after 32 shift cycles; WRITE->IDLE after one cycle.
REQ-016 SHALL in CONV run double-dabble one bit per cycle: each of the 8 BCD digits >=5 gets +3, then the 64-bit {bcd,bin} shifts left by 1; a 6-bit counter counts 32 cycles.
REQ-017 SHALL set sticky range flag (STATUS bit3) when the accepted value exceeds 99_999_999 and clear it on the next in-range accepted write.
REQ-018 SHALL in WRITE drive tube_WE=1, tube_Addr=0x0000_7f38, tube_Din=8-digit packed BCD (digit 0 in [3:0]), or the raw value_reg when range flag is set; exactly one cycle.
REQ-019 SHALL drive tube_WE=0, tube_Addr=0, tube_Din=0 in every state except WRITE.
REQ-020 SHALL give latency: in-range tube_WE high in the 33rd cycle after the accepting edge; out-of-range in the 1st.
REQ-021 SHALL set sticky done (STATUS bit1) on the WRITE->IDLE edge.
REQ-022 SHALL clear done when STATUS is written with WE=1, BE[0]=1, Din[1]=1, and clear overrun when Din[2]=1; when setting and clearing coincide on one edge, set wins.
REQ-023 SHALL return on Dout: VALUE -> value_reg; STATUS -> {28'd0, range, overrun, done, busy} with busy=(state!=IDLE); outside window -> 0.

Reset
REQ-024 SHALL, while reset=0, asynchronously force state=IDLE, value_reg=0, shift register=0, counter=0, done=overrun=range=0, tube_WE=0, tube_Addr=0, tube_Din=0.
REQ-025 SHALL abort any conversion on reset assertion with no tube write; the first clk edge after reset release shall not accept a bus write.

Verification
REQ-026 SHALL verify: write VALUE=0x00BC614E (12345678) -> cycle 33 tube_WE=1, tube_Addr=0x7f38, tube_Din=0x12345678; then STATUS reads 0x2.
REQ-027 SHALL verify: write VALUE=0x05F5E0FF (99999999) -> tube_Din=0x99999999 at cycle 33, range=0; write 0 -> tube_Din=0x00000000.
REQ-028 SHALL verify: write VALUE=0x05F5E100 -> cycle 1 tube_WE=1, tube_Din=0x05F5E100; STATUS reads 0xA.
REQ-029 SHALL verify: write 0x1234 then write 0x9999 at cycle 5 -> tube_Din=0x00004660, STATUS bit2=1; STATUS write Din=0x4 clears overrun only.
REQ-030 SHALL verify: write VALUE, pull reset low at cycle 10 -> tube_WE never asserts, STATUS=0, VALUE reads 0.
REQ-031 SHALL verify: STATUS write Din=0x2 on the same edge done sets -> done reads 1; BE=4'b0011 VALUE write -> ignored, busy stays 0.

Source files
------------

// File: rtl/bcd_tube_feeder.sv
// bcd_tube_feeder: memory-mapped binary-to-BCD converter that forwards the
// 8-digit packed BCD result (or the raw value when out of range) to a tube
// display driver as a single-cycle bus write.
module bcd_tube_feeder (
    input  logic        clk,
    input  logic        reset,
    input  logic        WE,
    input  logic [3:0]  BE,
    input  logic [31:0] Addr,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    output logic        tube_WE,
    output logic [31:0] tube_Addr,
    output logic [31:0] tube_Din
);

    localparam int unsigned DW     = 32;
    localparam int unsigned SW     = 2 * DW;
    localparam int unsigned DIGITS = 8;
    localparam int unsigned CW     = 6;
    localparam int unsigned AW_HI  = 29;

    localparam logic [CW-1:0]    LAST_SHIFT = CW'(31);
    localparam logic [DW-1:0]    MAX_BCD    = DW'(99_999_999);
    localparam logic [DW-1:0]    TUBE_ADDR  = 32'h0000_7f38;
    localparam logic [AW_HI-1:0] WIN_BASE   = AW_HI'(32'h0000_7f40 >> 3);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CONV  = 2'd1,
        WRITE = 2'd2
    } state_e;

    state_e          state_q;
    logic [DW-1:0]   value_q;
    logic [SW-1:0]   shift_q;
    logic [SW-1:0]   shift_d;
    logic [CW-1:0]   cnt_q;
    logic            done_q;
    logic            ovr_q;
    logic            range_q;
    logic            armed_q;

    logic            in_win_c;
    logic            busy_c;
    logic            value_wr_c;
    logic            status_wr_c;
    logic            addr_lsb_unused;

    assign in_win_c        = (Addr[31:3] == WIN_BASE);
    assign busy_c          = (state_q != IDLE);
    assign value_wr_c      = armed_q & WE & in_win_c & ~Addr[2] & (BE == 4'hF);
    assign status_wr_c     = armed_q & WE & in_win_c &  Addr[2] & BE[0];
    assign addr_lsb_unused = ^Addr[1:0];

    // One double-dabble step: add 3 to every digit >= 5, then shift left.
    always_comb begin
        logic [SW-1:0] adj;
        adj = shift_q;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (adj[DW + 4*i +: 4] >= 4'd5) begin
                adj[DW + 4*i +: 4] = adj[DW + 4*i +: 4] + 4'd3;
            end
        end
        shift_d = {adj[SW-2:0], 1'b0};
    end

    // Combinational register read-back.
    always_comb begin
        Dout = '0;
        if (in_win_c) begin
            if (Addr[2]) begin
                Dout = {28'd0, range_q, ovr_q, done_q, busy_c};
            end else begin
                Dout = value_q;
            end
        end
    end

    // Conversion FSM, sticky status flags and registered tube bus outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            value_q   <= '0;
            shift_q   <= '0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            ovr_q     <= 1'b0;
            range_q   <= 1'b0;
            armed_q   <= 1'b0;
            tube_WE   <= 1'b0;
            tube_Addr <= '0;
            tube_Din  <= '0;
        end else begin
            // Bus writes are ignored on the first edge after reset release.
            armed_q   <= 1'b1;
            tube_WE   <= 1'b0;
            tube_Addr <= '0;
            tube_Din  <= '0;

            if (value_wr_c && busy_c) begin
                ovr_q <= 1'b1;
            end else if (status_wr_c && Din[2]) begin
                ovr_q <= 1'b0;
            end

            // Completion setting done beats a simultaneous software clear.
            if (state_q == WRITE) begin
                done_q <= 1'b1;
            end else if (status_wr_c && Din[1]) begin
                done_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (value_wr_c) begin
                        value_q <= Din;
                        cnt_q   <= '0;
                        if (Din > MAX_BCD) begin
                            range_q   <= 1'b1;
                            state_q   <= WRITE;
                            tube_WE   <= 1'b1;
                            tube_Addr <= TUBE_ADDR;
                            tube_Din  <= Din;
                        end else begin
                            range_q <= 1'b0;
                            shift_q <= {DW'(0), Din};
                            state_q <= CONV;
                        end
                    end
                end
                CONV: begin
                    shift_q <= shift_d;
                    cnt_q   <= cnt_q + CW'(1);
                    if (cnt_q == LAST_SHIFT) begin
                        state_q   <= WRITE;
                        tube_WE   <= 1'b1;
                        tube_Addr <= TUBE_ADDR;
                        tube_Din  <= range_q ? value_q : shift_d[SW-1:DW];
                    end
                end
                WRITE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_tube_feeder.sv
// Testbench for bcd_tube_feeder: directed scenarios with literal expectations
// plus randomized bus traffic, all checked every cycle against a behavioural
// model built from decimal arithmetic and a countdown to the tube write.
module tb_bcd_tube_feeder;

    logic        clk = 1'b0;
    logic        reset;
    logic        WE;
    logic [3:0]  BE;
    logic [31:0] Addr;
    logic [31:0] Din;
    logic [31:0] Dout;
    logic        tube_WE;
    logic [31:0] tube_Addr;
    logic [31:0] tube_Din;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bcd_tube_feeder dut (
        .clk      (clk),
        .reset    (reset),
        .WE       (WE),
        .BE       (BE),
        .Addr     (Addr),
        .Din      (Din),
        .Dout     (Dout),
        .tube_WE  (tube_WE),
        .tube_Addr(tube_Addr),
        .tube_Din (tube_Din)
    );

    // ---------------- behavioural model ----------------
    logic [31:0] m_value = '0;
    logic [31:0] m_tdin  = '0;
    int          m_left  = 0;
    bit          m_tw    = 1'b0;
    bit          m_done  = 1'b0;
    bit          m_ovr   = 1'b0;
    bit          m_rng   = 1'b0;
    bit          m_ready = 1'b0;

    function automatic bit in_win(input logic [31:0] a);
        return (a >= 32'h0000_7f40) && (a <= 32'h0000_7f47);
    endfunction

    function automatic logic [31:0] to_bcd(input logic [31:0] v);
        logic [31:0] r;
        int unsigned x;
        r = '0;
        x = v;
        for (int i = 0; i < 8; i++) begin
            r[i*4 +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic bit m_busy();
        return (m_left > 0) || m_tw;
    endfunction

    function automatic logic [31:0] exp_dout();
        if (!in_win(Addr)) return 32'd0;
        if (Addr[2]) return {28'd0, m_rng, m_ovr, m_done, m_busy()};
        return m_value;
    endfunction

    always @(posedge clk or negedge reset) begin
        bit busy, wv, ws, dset;
        if (!reset) begin
            m_value = '0; m_tdin = '0; m_left = 0; m_tw = 1'b0;
            m_done = 1'b0; m_ovr = 1'b0; m_rng = 1'b0; m_ready = 1'b0;
        end else begin
            busy = m_busy();
            wv   = m_ready && WE && in_win(Addr) && !Addr[2] && (BE == 4'hF);
            ws   = m_ready && WE && in_win(Addr) &&  Addr[2] && BE[0];
            dset = m_tw;
            if (m_tw) begin
                m_tw = 1'b0;
            end else if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_tw   = 1'b1;
                    m_tdin = m_rng ? m_value : to_bcd(m_value);
                end
            end else if (wv) begin
                m_value = Din;
                if (Din > 32'd99_999_999) begin
                    m_rng  = 1'b1;
                    m_tw   = 1'b1;
                    m_tdin = Din;
                end else begin
                    m_rng  = 1'b0;
                    m_left = 32;
                end
            end
            if (wv && busy)     m_ovr  = 1'b1;
            if (ws && Din[1])   m_done = 1'b0;
            if (ws && Din[2])   m_ovr  = 1'b0;
            if (dset)           m_done = 1'b1;
            m_ready = 1'b1;
        end
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("tube_WE",   32'(tube_WE), 32'(m_tw));
        chk("tube_Addr", tube_Addr, m_tw ? 32'h0000_7f38 : 32'd0);
        chk("tube_Din",  tube_Din,  m_tw ? m_tdin : 32'd0);
        chk("Dout",      Dout,      exp_dout());
    endtask

    // One clock: compare on the falling edge, return #1 after the rising edge.
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            compare_all();
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle_bus();
        WE = 1'b0; BE = 4'h0; Addr = '0; Din = '0;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        WE = 1'b1; Addr = a; Din = d; BE = be;
        tick();
        idle_bus();
    endtask

    task automatic read_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
        WE = 1'b0; Addr = a;
        #1;
        chk(name, Dout, exp);
    endtask

    task automatic wait_tube(input int max);
        int n;
        n = 0;
        while (!tube_WE && n < max) begin
            tick();
            n++;
        end
        chk("tube_WE_wait", 32'(tube_WE), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int seen;
        reset = 1'b1;
        idle_bus();
        #2 reset = 1'b0;
        tick(3);
        chk("rst_tube_WE", 32'(tube_WE), 32'd0);
        read_chk("rst_status", 32'h7f44, 32'd0);
        read_chk("rst_value",  32'h7f40, 32'd0);

        // Release reset with a write present on the very first edge: ignored.
        reset = 1'b1;
        bus_write(32'h7f40, 32'd5, 4'hF);
        read_chk("first_edge_value",  32'h7f40, 32'd0);
        read_chk("first_edge_status", 32'h7f44, 32'd0);
        tick();

        // 12345678 converts with 33-cycle latency.
        bus_write(32'h7f40, 32'h00BC614E, 4'hF);
        tick(31);
        chk("c32_tube_WE", 32'(tube_WE), 32'd0);
        tick();
        chk("c33_tube_WE",   32'(tube_WE), 32'd1);
        chk("c33_tube_Addr", tube_Addr, 32'h0000_7f38);
        chk("c33_tube_Din",  tube_Din,  32'h12345678);
        chk("model_bcd_1",   m_tdin,    32'h12345678);
        tick();
        read_chk("status_after_1", 32'h7f44, 32'h2);
        tick();

        // Largest in-range value, then zero.
        bus_write(32'h7f40, 32'h05F5E0FF, 4'hF);
        tick(32);
        chk("max_tube_Din", tube_Din, 32'h99999999);
        chk("model_bcd_max", m_tdin, 32'h99999999);
        tick();
        read_chk("max_status", 32'h7f44, 32'h2);
        bus_write(32'h7f40, 32'd0, 4'hF);
        tick(32);
        chk("zero_tube_WE",  32'(tube_WE), 32'd1);
        chk("zero_tube_Din", tube_Din, 32'h0);
        tick();

        // First out-of-range value: raw pass-through in cycle 1.
        bus_write(32'h7f40, 32'h05F5E100, 4'hF);
        chk("oor_tube_WE",  32'(tube_WE), 32'd1);
        chk("oor_tube_Din", tube_Din, 32'h05F5E100);
        tick();
        read_chk("oor_status", 32'h7f44, 32'hA);
        tick();

        // Overrun: second write mid-conversion is dropped.
        bus_write(32'h7f40, 32'h1234, 4'hF);
        tick(4);
        bus_write(32'h7f40, 32'h9999, 4'hF);
        wait_tube(40);
        chk("ovr_tube_Din", tube_Din, 32'h00004660);
        chk("model_bcd_ovr", m_tdin, 32'h00004660);
        tick();
        read_chk("ovr_status", 32'h7f44, 32'h6);
        read_chk("ovr_value",  32'h7f40, 32'h1234);
        bus_write(32'h7f44, 32'h4, 4'hF);
        read_chk("ovr_cleared", 32'h7f44, 32'h2);
        tick();

        // Done clear colliding with done set: set wins.
        bus_write(32'h7f44, 32'h2, 4'h1);
        read_chk("done_cleared", 32'h7f44, 32'h0);
        bus_write(32'h7f40, 32'd7, 4'hF);
        wait_tube(40);
        WE = 1'b1; Addr = 32'h7f44; Din = 32'h2; BE = 4'h1;
        tick();
        idle_bus();
        read_chk("set_wins", 32'h7f44, 32'h2);
        bus_write(32'h7f40, 32'h77, 4'h3);
        read_chk("partial_be_status", 32'h7f44, 32'h2);
        read_chk("partial_be_value",  32'h7f40, 32'd7);
        tick();

        // Reset mid-conversion: no tube write ever appears.
        bus_write(32'h7f40, 32'h55, 4'hF);
        tick(9);
        reset = 1'b0;
        #1;
        chk("abort_tube_WE", 32'(tube_WE), 32'd0);
        tick(2);
        read_chk("abort_status", 32'h7f44, 32'd0);
        read_chk("abort_value",  32'h7f40, 32'd0);
        reset = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (tube_WE) seen++;
            tick();
        end
        chk("abort_no_write", 32'(seen), 32'd0);

        // Randomized traffic against the model.
        for (int it = 0; it < 400; it++) begin
            int unsigned op;
            op = $urandom_range(0, 11);
            idle_bus();
            case (op)
                0, 1, 2: begin
                    WE = 1'b1; BE = 4'hF; Addr = 32'h7f40 | 32'($urandom_range(0, 3));
                    case ($urandom_range(0, 5))
                        0:       Din = $urandom;
                        1:       Din = 32'd99_999_999 + 32'($urandom_range(0, 1));
                        default: Din = 32'($urandom_range(0, 99_999_999));
                    endcase
                end
                3: begin
                    WE = 1'b1; BE = 4'($urandom_range(0, 14)); Addr = 32'h7f40; Din = $urandom;
                end
                4: begin
                    WE = 1'b1; BE = 4'($urandom_range(0, 15)); Addr = 32'h7f44 | 32'($urandom_range(0, 3));
                    Din = 32'($urandom_range(0, 7));
                end
                5: begin
                    WE = 1'b1; BE = 4'hF; Din = $urandom;
                    Addr = ($urandom_range(0, 1) == 0) ? 32'h7f48 : 32'h7f3c;
                end
                6: begin
                    reset = 1'b0;
                    tick();
                    reset = 1'b1;
                end
                default: begin
                    Addr = ($urandom_range(0, 3) == 0) ? $urandom : (32'h7f40 | 32'($urandom_range(0, 7)));
                end
            endcase
            tick();
        end
        idle_bus();
        tick(40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
